// File: rtl/pipe_stage_elastic_pkg.sv
// Shared types and defaults for the elastic pipeline register.
package pipe_pkg;

  // Occupancy of the stage: no entry, main entry only, main plus skid entry.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_t;

  localparam int unsigned PIPE_W_DEF     = 32;
  localparam int unsigned PIPE_CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready handshake bundle for one pipeline stage (upstream and downstream side).
// slave  : the stage itself.
// master : the environment driving the stage (producer and consumer).
interface pipe_stage_elastic_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_elastic_sat_cnt.sv
// Saturating event counter used for stage performance monitoring.
module pipe_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count cycles with inc set, sticking at the all-ones value; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Generic elastic pipeline register with valid/ready handshake, synchronous
// flush and an optional skid entry (SKID=1 gives a registered in_ready).
// Optional stall/bubble counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned W     = PIPE_W_DEF,
  parameter int unsigned SKID  = 1,
  parameter int unsigned CNT_W = PIPE_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_stage_elastic_if.slave   bus
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      bubble_cnt
`endif
);

  pipe_state_t  r_state;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         r_out_valid;
  logic         r_in_ready;

  logic         w_in_ready;
  logic         w_in_fire;
  logic         w_out_fire;

  // With a skid entry in_ready comes from a flop; without it, the stage can
  // accept whenever it is empty or its current entry leaves this cycle.
  generate
    if (SKID != 0) begin : g_skid
      assign w_in_ready = r_in_ready;
    end else begin : g_noskid
      assign w_in_ready = !r_out_valid | bus.out_ready;
    end
  endgenerate

  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_main;

  // Occupancy FSM: main entry always drives out_data, skid entry absorbs the
  // one payload accepted while downstream stalls. Flush overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main      <= {W{1'b0}};
      r_skid      <= {W{1'b0}};
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_main      <= {W{1'b0}};
      r_skid      <= {W{1'b0}};
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_state     <= ST_ONE;
            r_main      <= bus.in_data;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= bus.in_data;
          end else if (w_in_fire) begin
            // Only reachable with SKID=1: downstream stalled, park in skid.
            r_state    <= ST_TWO;
            r_skid     <= bus.in_data;
            r_in_ready <= 1'b0;
          end else if (w_out_fire) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            r_state    <= ST_ONE;
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_main      <= {W{1'b0}};
          r_skid      <= {W{1'b0}};
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic w_stall;
  logic w_bubble;

  assign w_stall  = r_out_valid & !bus.out_ready;
  assign w_bubble = !r_out_valid;

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stall),
    .cnt (stall_cnt)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_bubble),
    .cnt (bubble_cnt)
  );
`endif

endmodule
